// File: rtl/reg_bus_arbiter_pkg.sv
// rtl/reg_bus_arbiter_pkg.sv - shared types for the two-requester register bus arbiter
//
// Purpose: FSM state encoding, the latched-request record and a small
// helper used by the arbiter top and its grant sub-module.
// Ports: none (package).
package reg_bus_arbiter_pkg;

    // The latched request is stored at these fixed maximum widths so the
    // record can be shared regardless of the arbiter's width parameters;
    // the arbiter zero-extends into it and truncates out of it.
    localparam int REQ_ADDR_MAX = 64;
    localparam int REQ_DATA_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ARB_STATE;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_MAX-1:0] address;
        logic [REQ_DATA_MAX-1:0] data;
        logic                    index;
    } REG_BUS_REQ;

    // Requester index to its one-hot response bit.
    function automatic logic [1:0] req_onehot(input logic index);
        return index ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_grant_select.sv
// rtl/reg_bus_arbiter_grant_select.sv - two-way round-robin grant
//
// Purpose: pick one requester from valid[1:0]; on a tie the requester that
// was not granted last wins.
// Ports:
//   valid  in  2  request valid per requester
//   last   in  1  index of the requester granted on the last transfer
//   grant  out 2  one-hot grant (zero when nothing is valid)
module arb_grant_select (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-requester register bus arbiter with single-outstanding FSM
//
// Purpose: accept one request at a time from two requesters (round-robin),
// drive it to a register file, and return a one-cycle completion pulse
// (with read data for reads) to the requester that issued it.
// Ports:
//   ipClk       in   1             clock, rising edge
//   ipReset     in   1             asynchronous active-high reset
//   ipValid     in   2             per-requester request valid
//   ipWrite     in   2             per-requester direction (1 = write)
//   ipAddress   in   2*ADDR_WIDTH  requester n address at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   ipWrData    in   2*DATA_WIDTH  requester n write data at [n*DATA_WIDTH +: DATA_WIDTH]
//   opReady     out  2             per-requester accept (combinational)
//   opRspValid  out  2             per-requester completion pulse
//   opRspData   out  DATA_WIDTH    read data, qualified by opRspValid
//   opAddress   out  ADDR_WIDTH    register file address
//   opWrData    out  DATA_WIDTH    register file write data
//   opWrEnable  out  1             one-cycle register write strobe
//   ipRdData    in   DATA_WIDTH    register file read data, one cycle after opAddress
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  logic [1:0]              ipValid,
    input  logic [1:0]              ipWrite,
    input  logic [2*ADDR_WIDTH-1:0] ipAddress,
    input  logic [2*DATA_WIDTH-1:0] ipWrData,
    output logic [1:0]              opReady,
    output logic [1:0]              opRspValid,
    output logic [DATA_WIDTH-1:0]   opRspData,
    output logic [ADDR_WIDTH-1:0]   opAddress,
    output logic [DATA_WIDTH-1:0]   opWrData,
    output logic                    opWrEnable,
    input  logic [DATA_WIDTH-1:0]   ipRdData
);

    ARB_STATE   state;
    REG_BUS_REQ req_q;
    REG_BUS_REQ accept_req;
    logic       last_q;
    logic [1:0] grant;
    logic       accept;
    logic       sel;

    arb_grant_select u_grant_select (
        .valid (ipValid),
        .last  (last_q),
        .grant (grant)
    );

    // Only offer a grant while idle; nothing is accepted mid-transaction.
    assign opReady = (state == ST_IDLE) ? (grant & ipValid) : 2'b00;
    assign accept  = |opReady;
    assign sel     = opReady[1];

    always_comb begin
        accept_req         = '0;
        accept_req.write   = sel ? ipWrite[1] : ipWrite[0];
        accept_req.index   = sel;
        accept_req.address = REQ_ADDR_MAX'(sel ? ipAddress[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                               : ipAddress[ADDR_WIDTH-1:0]);
        accept_req.data    = REQ_DATA_MAX'(sel ? ipWrData[2*DATA_WIDTH-1:DATA_WIDTH]
                                               : ipWrData[DATA_WIDTH-1:0]);
    end

    // The latched request drives the bus directly, so address and write
    // data appear at ISSUE and hold until the next accepted transfer.
    assign opAddress = req_q.address[ADDR_WIDTH-1:0];
    assign opWrData  = req_q.data[DATA_WIDTH-1:0];

    // Bits above the configured widths are always zero-filled.
    logic unused_req_bits;
    assign unused_req_bits = ^(req_q.address >> ADDR_WIDTH) ^ ^(req_q.data >> DATA_WIDTH);

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            last_q     <= 1'b1;     // requester 0 wins the first tie
            opWrEnable <= 1'b0;
            opRspValid <= 2'b00;
            opRspData  <= '0;
        end else begin
            opWrEnable <= 1'b0;
            opRspValid <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q      <= accept_req;
                        last_q     <= sel;
                        opWrEnable <= accept_req.write;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (req_q.write) begin
                        opRspData  <= '0;
                        opRspValid <= req_onehot(req_q.index);
                        state      <= ST_RESP;
                    end else begin
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Register file data is valid one cycle after the address.
                    opRspData  <= ipRdData;
                    opRspValid <= req_onehot(req_q.index);
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - scoreboard bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    logic              ipClk = 1'b0;
    logic              ipReset;
    logic [1:0]        ipValid;
    logic [1:0]        ipWrite;
    logic [2*AW-1:0]   ipAddress;
    logic [2*DW-1:0]   ipWrData;
    logic [1:0]        opReady;
    logic [1:0]        opRspValid;
    logic [DW-1:0]     opRspData;
    logic [AW-1:0]     opAddress;
    logic [DW-1:0]     opWrData;
    logic              opWrEnable;
    logic [DW-1:0]     ipRdData;

    reg_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipValid    (ipValid),
        .ipWrite    (ipWrite),
        .ipAddress  (ipAddress),
        .ipWrData   (ipWrData),
        .opReady    (opReady),
        .opRspValid (opRspValid),
        .opRspData  (opRspData),
        .opAddress  (opAddress),
        .opWrData   (opWrData),
        .opWrEnable (opWrEnable),
        .ipRdData   (ipRdData)
    );

    always #5 ipClk = ~ipClk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge ipClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-on content of any register never written.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'h12345677 + DW'(a);
    endfunction

    // Register file attached to the DUT: registered read, one cycle latency.
    logic [DW-1:0] rf [0:255];
    logic [255:0]  rf_written = '0;
    always @(posedge ipClk) begin
        if (opWrEnable) begin
            rf[opAddress]         <= opWrData;
            rf_written[opAddress] <= 1'b1;
        end
        ipRdData <= rf_written[opAddress] ? rf[opAddress] : init_val(opAddress);
    end

    // ---------------- reference model ----------------
    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
    typedef struct { int cyc; logic [1:0] onehot; logic [DW-1:0] data; } rsp_exp_t;
    wr_exp_t  wr_q[$];
    rsp_exp_t rsp_q[$];

    logic [DW-1:0] mem_model [int];
    int            busy_cnt = 0;
    logic          prefer   = 1'b0;     // requester that wins the next tie
    logic          pend_write;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [1:0]    exp_ready;
    int            m_n;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return init_val(a);
    endfunction

    // A write completes (strobe) one cycle after accept, the response comes
    // in the 3rd cycle counting the accept cycle; a read responds in the 4th.
    always @(negedge ipClk) begin
        if (ipReset) begin
            check("reset_rsp_valid", opRspValid, 0);
            check("reset_rsp_data", opRspData, 0);
            check("reset_address", opAddress, 0);
            check("reset_wr_data", opWrData, 0);
            check("reset_wr_enable", opWrEnable, 0);
            busy_cnt  = 0;
            prefer    = 1'b0;
            exp_addr  = '0;
            exp_wdata = '0;
            wr_q.delete();
            rsp_q.delete();
        end else begin
            check("address_hold", opAddress, exp_addr);
            check("wr_data_hold", opWrData, exp_wdata);
            if (busy_cnt > 0) begin
                check("ready_while_busy", opReady, 0);
                if (pend_write && busy_cnt == 2) mem_model[int'(pend_addr)] = pend_data;
                busy_cnt--;
            end else begin
                exp_ready = (ipValid == 2'b11) ? (prefer ? 2'b10 : 2'b01) : ipValid;
                check("ready_grant", opReady, exp_ready);
                if (exp_ready != 2'b00) begin
                    m_n    = exp_ready[1] ? 1 : 0;
                    m_addr = ipAddress[m_n*AW +: AW];
                    m_data = ipWrData[m_n*DW +: DW];
                    prefer = (m_n == 0);
                    exp_addr  = m_addr;
                    exp_wdata = m_data;
                    if (ipWrite[m_n]) begin
                        wr_q.push_back('{cyc + 1, m_addr, m_data});
                        rsp_q.push_back('{cyc + 2, exp_ready, '0});
                        busy_cnt   = 2;
                        pend_write = 1'b1;
                        pend_addr  = m_addr;
                        pend_data  = m_data;
                    end else begin
                        rsp_q.push_back('{cyc + 3, exp_ready, model_rd(m_addr)});
                        busy_cnt   = 3;
                        pend_write = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    wr_exp_t  w_e;
    rsp_exp_t r_e;
    always @(negedge ipClk) begin
        if (!ipReset) begin
            if (opWrEnable) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_wr_enable", opWrEnable, 0);
                end else begin
                    w_e = wr_q.pop_front();
                    check("wr_cycle", cyc, w_e.cyc);
                    check("wr_addr", opAddress, w_e.addr);
                    check("wr_data", opWrData, w_e.data);
                end
            end
            if (opRspValid != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp_valid", opRspValid, 0);
                end else begin
                    r_e = rsp_q.pop_front();
                    check("rsp_cycle", cyc, r_e.cyc);
                    check("rsp_valid", opRspValid, r_e.onehot);
                    check("rsp_data", opRspData, r_e.data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] acc;

    // One clock: note which requesters transfer, then retire them.
    task automatic step();
        @(negedge ipClk);
        acc = ipValid & opReady;
        @(posedge ipClk);
        #1;
        ipValid = ipValid & ~acc;
    endtask

    task automatic arm(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ipValid[n]           = 1'b1;
        ipWrite[n]           = w;
        ipAddress[n*AW +: AW] = a;
        ipWrData[n*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        ipReset = 1'b1;
        ipValid = 2'b00;
        repeat (2) @(posedge ipClk);
        #1;
        ipReset = 1'b0;
    endtask

    initial begin
        ipReset   = 1'b1;
        ipValid   = 2'b00;
        ipWrite   = 2'b00;
        ipAddress = '0;
        ipWrData  = '0;
        acc       = 2'b00;
        do_reset();

        // single write, then single read of a never-written register
        arm(0, 1'b1, 8'h02, 32'h000000A5);
        repeat (6) step();
        arm(1, 1'b0, 8'h01, 32'h0);
        repeat (6) step();

        // contention from reset: both keep reading
        do_reset();
        arm(0, 1'b0, 8'h03, 32'h0);
        arm(1, 1'b0, 8'h04, 32'h0);
        repeat (16) begin
            step();
            if (!ipValid[0]) arm(0, 1'b0, 8'h03, 32'h0);
            if (!ipValid[1]) arm(1, 1'b0, 8'h04, 32'h0);
        end
        ipValid = 2'b00;
        repeat (6) step();

        // held request raised during ISSUE of another
        arm(0, 1'b1, 8'h10, 32'hCAFE0010);
        step();
        arm(1, 1'b0, 8'h10, 32'h0);
        repeat (8) step();

        // withdrawn request while busy
        arm(1, 1'b1, 8'h20, 32'h00002020);
        step();
        arm(0, 1'b1, 8'h21, 32'h00002121);
        step();
        ipValid[0] = 1'b0;
        repeat (6) step();

        // reset during write ISSUE, then a tie and a read of that address
        arm(0, 1'b1, 8'h05, 32'hDEADBEEF);
        step();
        do_reset();
        arm(0, 1'b0, 8'h05, 32'h0);
        arm(1, 1'b0, 8'h06, 32'h0);
        repeat (10) step();

        // randomized traffic
        repeat (3000) begin
            step();
            for (int n = 0; n < 2; n++) begin
                if (!ipValid[n]) begin
                    if ($urandom_range(0, 1) == 1)
                        arm(n, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
                end else if ($urandom_range(0, 15) == 0) begin
                    ipValid[n] = 1'b0;
                end
            end
        end
        ipValid = 2'b00;
        repeat (8) step();

        check("pending_writes", wr_q.size(), 0);
        check("pending_responses", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, register address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 ipClk  input  1  single clock; all state updates on its rising edge.
REQ-005 ipReset  input  1  asynchronous, active-high reset.
REQ-006 ipValid  input  2  per-requester request valid; bit n is requester n.
REQ-007 ipWrite  input  2  per-requester direction: 1 = write, 0 = read.
REQ-008 ipAddress  input  2*ADDR_WIDTH  requester n address in bits [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 ipWrData  input  2*DATA_WIDTH  requester n write data in bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-010 opReady  output  2  per-requester accept; combinational.
REQ-011 opRspValid  output  2  per-requester one-cycle completion pulse.
REQ-012 opRspData  output  DATA_WIDTH  read data, qualified by opRspValid.
REQ-013 opAddress  output  ADDR_WIDTH  address to the register file.
REQ-014 opWrData  output  DATA_WIDTH  write data to the register file.
REQ-015 opWrEnable  output  1  one-cycle register write strobe.
REQ-016 ipRdData  input  DATA_WIDTH  register file read data, valid one cycle after opAddress.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> (WAIT for reads only) -> RESP -> IDLE.
REQ-018 In IDLE, opReady SHALL equal the one-hot grant masked by ipValid; in all other states opReady SHALL be 0.
REQ-019 A transfer occurs on the edge where ipValid[n] and opReady[n] are both high; at that edge the arbiter SHALL latch write, address, data and the requester index.
REQ-020 Grant SHALL be round-robin: a single valid requester wins; when both are valid, the requester not granted last wins.
REQ-021 SHALL update the last-grant pointer only on an accepted transfer.
REQ-022 In ISSUE, opAddress and opWrData SHALL present the latched values (registered); opWrEnable SHALL be 1 for exactly this cycle if write, else 0.
REQ-023 Read: ISSUE -> WAIT, and opAddress SHALL hold through WAIT.
REQ-024 At the end of WAIT, SHALL capture ipRdData into opRspData.
REQ-025 Write: ISSUE -> RESP, and opRspData SHALL be 0.
REQ-026 In RESP, opRspValid[granted] SHALL be 1 for exactly one cycle; the other bit SHALL be 0; then return to IDLE.
REQ-027 Latency: write SHALL be 3 cycles from accept edge to RESP end; read SHALL be 4 cycles.
REQ-028 Requests arriving during a busy transaction SHALL wait; they SHALL NOT be lost if held.
REQ-029 If ipValid drops before acceptance, no transaction SHALL occur.
REQ-030 opAddress and opWrData SHALL hold the last value between transactions.
REQ-031 opWrEnable SHALL never assert for reads or outside ISSUE.
REQ-032 Addresses SHALL pass through unmodified; range decoding belongs to the register file.

Reset
REQ-033 On ipReset: state = IDLE; opRspValid = 0; opRspData = 0; opAddress = 0; opWrData = 0; opWrEnable = 0; pointer favours requester 0 at the first tie.
REQ-034 Reset mid-transaction SHALL abandon it: no opWrEnable and no opRspValid afterwards.

Structure
REQ-035 The FSM state enum (ARB_STATE) and the latched-request struct (REG_BUS_REQ: write, address, data, index) SHALL live in the shared Structures package.
REQ-036 The round-robin grant logic SHALL be one combinational sub-module, arb_grant_select (inputs: valid[1:0], last; output: one-hot grant).

Verification
REQ-037 Single write: req0 write addr 0x02 data 0x000000A5 -> opWrEnable one cycle at ISSUE with addr 0x02, data 0xA5; opRspValid=01 two cycles later.
REQ-038 Single read: req1 read addr 0x01 while ipRdData=0x12345678 -> opRspData=0x12345678, opRspValid=10, 4 cycles after accept.
REQ-039 Contention: both valid continuously after reset, reads -> grant order 0,1,0,1; each rsp on correct bit; no opReady while busy.
REQ-040 Held request: req1 asserts during req0 ISSUE -> accepted in next IDLE; no lost or duplicate transaction.
REQ-041 Reset in ISSUE of a write -> opWrEnable low from reset on, no opRspValid, all outputs 0, next tie grants requester 0.
REQ-042 Withdrawn request: req0 valid one cycle while arbiter busy, then low -> no transaction, no response.
